// File: rtl/uart_auth_rx.sv
// 8N1 UART receiver feeding the rider authorization FSM that gates motor power.
// 'G' enables power; 'S' disables it immediately if no rider is present, otherwise once the rider steps off.
module uart_auth_rx #(
    parameter int          BAUD_DIV = 2604,
    parameter logic [7:0]  CMD_GO   = 8'h47,
    parameter logic [7:0]  CMD_STOP = 8'h53
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       rider_off,
    output logic       pwr_up,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    output logic       frm_err
);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {AUTH_OFF, AUTH_PWR1, AUTH_PWR2} auth_state_t;

    // Counter runs N-1 down to 0, so each bit period is exactly BAUD_DIV clocks.
    localparam logic [11:0] BIT_RELOAD  = 12'(BAUD_DIV - 1);
    localparam logic [11:0] HALF_RELOAD = 12'(BAUD_DIV / 2 - 1);

    logic        rx_meta_q, rx_meta_d;
    logic        rx_sync_q, rx_sync_d;
    rx_state_t   rx_state_q, rx_state_d;
    logic [11:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_rdy_q, rx_rdy_d;
    logic        frm_err_q, frm_err_d;
    auth_state_t auth_q, auth_d;
    logic        pwr_up_q, pwr_up_d;

    logic baud_tick;
    logic cmd_go;
    logic cmd_stop;

    assign baud_tick = (cnt_q == 12'd0);
    assign cmd_go    = rx_rdy_q && (rx_data_q == CMD_GO);
    assign cmd_stop  = rx_rdy_q && (rx_data_q == CMD_STOP);

    always_comb begin
        rx_meta_d  = RX;
        rx_sync_d  = rx_meta_q;
        rx_state_d = rx_state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rx_rdy_d   = 1'b0;
        frm_err_d  = 1'b0;

        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_sync_q) begin
                    rx_state_d = RX_START;
                    cnt_d      = HALF_RELOAD;
                end
            end
            RX_START: begin
                if (!baud_tick) begin
                    cnt_d = cnt_q - 12'd1;
                end else if (rx_sync_q) begin
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_state_d = RX_DATA;
                    cnt_d      = BIT_RELOAD;
                    bit_idx_d  = 3'd0;
                end
            end
            RX_DATA: begin
                if (!baud_tick) begin
                    cnt_d = cnt_q - 12'd1;
                end else begin
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    cnt_d     = BIT_RELOAD;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (!baud_tick) begin
                    cnt_d = cnt_q - 12'd1;
                end else begin
                    rx_state_d = RX_IDLE;
                    if (rx_sync_q) begin
                        rx_data_d = shift_q;
                        rx_rdy_d  = 1'b1;
                    end else begin
                        frm_err_d = 1'b1;
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // In PWR2 the rider leaving outranks a simultaneous 'G'.
    always_comb begin
        auth_d = auth_q;
        case (auth_q)
            AUTH_OFF: begin
                if (cmd_go) auth_d = AUTH_PWR1;
            end
            AUTH_PWR1: begin
                if (cmd_stop) auth_d = rider_off ? AUTH_OFF : AUTH_PWR2;
            end
            AUTH_PWR2: begin
                if (rider_off)   auth_d = AUTH_OFF;
                else if (cmd_go) auth_d = AUTH_PWR1;
            end
            default: auth_d = AUTH_OFF;
        endcase
        pwr_up_d = (auth_d != AUTH_OFF);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            cnt_q      <= 12'd0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_rdy_q   <= 1'b0;
            frm_err_q  <= 1'b0;
            auth_q     <= AUTH_OFF;
            pwr_up_q   <= 1'b0;
        end else begin
            rx_meta_q  <= rx_meta_d;
            rx_sync_q  <= rx_sync_d;
            rx_state_q <= rx_state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rx_rdy_q   <= rx_rdy_d;
            frm_err_q  <= frm_err_d;
            auth_q     <= auth_d;
            pwr_up_q   <= pwr_up_d;
        end
    end

    assign pwr_up  = pwr_up_q;
    assign rx_data = rx_data_q;
    assign rx_rdy  = rx_rdy_q;
    assign frm_err = frm_err_q;

endmodule

// File: tb/tb_uart_auth_rx.sv
// Directed bench for uart_auth_rx; a short bit period keeps whole command sequences quick to simulate.
module tb_uart_auth_rx;

    localparam int DIV = 64;
    localparam int LAT = 2 + DIV / 2 + 9 * DIV + 1;

    logic       clk;
    logic       rst;
    logic       RX;
    logic       rider_off;
    logic       pwr_up;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       frm_err;

    int errors = 0;
    int checks = 0;

    int         cyc = 0;
    int         rdy_cnt = 0;
    int         err_cnt = 0;
    int         last_rdy_cyc = 0;
    logic [7:0] rdy_byte = 8'h00;
    logic       pwr_at_rdy = 1'b0;
    logic       pwr_after_rdy = 1'b0;
    logic       rdy_prev = 1'b0;

    int start_cyc;
    int r0;
    int e0;
    int lat;

    uart_auth_rx #(
        .BAUD_DIV (DIV),
        .CMD_GO   (8'h47),
        .CMD_STOP (8'h53)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .RX        (RX),
        .rider_off (rider_off),
        .pwr_up    (pwr_up),
        .rx_data   (rx_data),
        .rx_rdy    (rx_rdy),
        .frm_err   (frm_err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rx_rdy) begin
            rdy_cnt      <= rdy_cnt + 1;
            last_rdy_cyc <= cyc;
            rdy_byte     <= rx_data;
            pwr_at_rdy   <= pwr_up;
        end
        if (rdy_prev) pwr_after_rdy <= pwr_up;
        rdy_prev <= rx_rdy;
        if (frm_err) err_cnt <= err_cnt + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Frame bit i is driven at the current falling edge; rst_bit pulses reset 3 clocks into that bit.
    task automatic applyStimulus(input logic [7:0] b, input logic stop_bit, input int rst_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            RX = frame[i];
            if (i == 0) start_cyc = cyc;
            if (i == rst_bit) begin
                rst = 1'b1;
                repeat (3) @(negedge clk);
                rst = 1'b0;
                repeat (DIV - 3) @(negedge clk);
            end else if (i == 9 && !stop_bit) begin
                repeat (DIV / 2 + 8) @(negedge clk);
                RX = 1'b1;
                repeat (DIV / 2 - 8) @(negedge clk);
            end else begin
                repeat (DIV) @(negedge clk);
            end
        end
        RX = 1'b1;
    endtask

    initial begin
        rst       = 1'b1;
        RX        = 1'b1;
        rider_off = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_pwr_up", pwr_up, 0);
        checkOutput("reset_rx_rdy", rx_rdy, 0);
        checkOutput("reset_frm_err", frm_err, 0);
        checkOutput("reset_rx_data", rx_data, 8'h00);
        rst = 1'b0;

        repeat (2000) @(negedge clk);
        checkOutput("idle_rdy_count", rdy_cnt, 0);
        checkOutput("idle_err_count", err_cnt, 0);
        checkOutput("idle_pwr_up", pwr_up, 0);

        r0 = rdy_cnt;
        applyStimulus(8'h47, 1'b1, -1);
        repeat (5) @(negedge clk);
        checkOutput("go_rdy_count", rdy_cnt - r0, 1);
        checkOutput("go_rdy_byte", rdy_byte, 8'h47);
        checkOutput("go_rx_data", rx_data, 8'h47);
        lat = last_rdy_cyc - start_cyc;
        checks++;
        assert (lat >= LAT - 2 && lat <= LAT + 2) else begin
            errors++;
            $error("[TB] FAIL go_latency: observed=%0d expected=%0d+-2", lat, LAT);
        end
        checkOutput("go_pwr_at_rdy", pwr_at_rdy, 0);
        checkOutput("go_pwr_after_rdy", pwr_after_rdy, 1);

        applyStimulus(8'h53, 1'b1, -1);
        repeat (5) @(negedge clk);
        checkOutput("stop_rider_on_byte", rdy_byte, 8'h53);
        checkOutput("stop_rider_on_pwr2", pwr_up, 1);
        rider_off = 1'b1;
        checkOutput("pwr2_before_edge", pwr_up, 1);
        @(negedge clk);
        checkOutput("pwr2_rider_off", pwr_up, 0);
        rider_off = 1'b0;

        r0 = rdy_cnt;
        applyStimulus(8'h47, 1'b1, -1);
        applyStimulus(8'h53, 1'b1, -1);
        repeat (5) @(negedge clk);
        checkOutput("b2b_rdy_count", rdy_cnt - r0, 2);
        checkOutput("b2b_pwr2", pwr_up, 1);
        applyStimulus(8'h47, 1'b1, -1);
        repeat (5) @(negedge clk);
        rider_off = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("pwr1_ignores_rider_off", pwr_up, 1);
        rider_off = 1'b0;

        applyStimulus(8'h58, 1'b1, -1);
        repeat (5) @(negedge clk);
        checkOutput("pwr1_bad_cmd_data", rx_data, 8'h58);
        checkOutput("pwr1_bad_cmd_pwr", pwr_up, 1);

        rider_off = 1'b1;
        applyStimulus(8'h53, 1'b1, -1);
        repeat (5) @(negedge clk);
        checkOutput("stop_rider_off_pwr", pwr_up, 0);
        applyStimulus(8'h41, 1'b1, -1);
        repeat (5) @(negedge clk);
        checkOutput("off_bad_cmd_data", rx_data, 8'h41);
        checkOutput("off_bad_cmd_pwr", pwr_up, 0);
        applyStimulus(8'h47, 1'b1, -1);
        repeat (5) @(negedge clk);
        checkOutput("go_rider_off_pwr", pwr_up, 1);
        applyStimulus(8'h53, 1'b1, -1);
        repeat (5) @(negedge clk);
        checkOutput("stop_again_pwr", pwr_up, 0);
        rider_off = 1'b0;

        r0 = rdy_cnt;
        e0 = err_cnt;
        applyStimulus(8'h47, 1'b0, -1);
        repeat (200) @(negedge clk);
        checkOutput("frm_err_count", err_cnt - e0, 1);
        checkOutput("frm_rdy_count", rdy_cnt - r0, 0);
        checkOutput("frm_pwr_up", pwr_up, 0);
        checkOutput("frm_rx_data_kept", rx_data, 8'h53);

        r0 = rdy_cnt;
        e0 = err_cnt;
        RX = 1'b0;
        repeat (10) @(negedge clk);
        RX = 1'b1;
        repeat (200) @(negedge clk);
        checkOutput("glitch_rdy_count", rdy_cnt - r0, 0);
        checkOutput("glitch_err_count", err_cnt - e0, 0);

        applyStimulus(8'h47, 1'b1, -1);
        repeat (5) @(negedge clk);
        checkOutput("pre_reset_pwr", pwr_up, 1);
        applyStimulus(8'h47, 1'b1, 5);
        checkOutput("mid_frame_reset_pwr", pwr_up, 0);
        repeat (1000) @(negedge clk);
        checkOutput("after_garble_pwr", pwr_up, 0);

        r0 = rdy_cnt;
        applyStimulus(8'h47, 1'b1, -1);
        repeat (5) @(negedge clk);
        checkOutput("clean_go_rdy_count", rdy_cnt - r0, 1);
        checkOutput("clean_go_rx_data", rx_data, 8'h47);
        checkOutput("clean_go_pwr", pwr_up, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_auth_rx.md
Name: uart_auth_rx

Overview:
- Receives BLE command bytes on the serial RX line.
- Decodes the 'G' (go) and 'S' (stop) commands into the registered power-enable `pwr_up`.
- Sits between the board RX pin and the balance controller / steering enable logic inside the Segway top level.
- Combines an 8N1 UART receiver with the authorization state machine that gates motor power on rider presence.

Parameters:
- BAUD_DIV, 2604, clocks per bit (50 MHz / 19200 baud).
- CMD_GO, 8'h47, ASCII 'G' command code.
- CMD_STOP, 8'h53, ASCII 'S' command code.

Ports:
- clk  input  1  system clock, 50 MHz
- rst  input  1  asynchronous active-high reset
- RX  input  1  asynchronous serial line, idle high
- rider_off  input  1  1 = load cells report no rider (synchronous to clk)
- pwr_up  output  1  registered power enable to balance/steer logic
- rx_data  output  8  last correctly framed byte
- rx_rdy  output  1  one-cycle pulse, rx_data valid
- frm_err  output  1  one-cycle pulse, stop bit sampled low

Behaviour:
- Reset (async, active-high) values:
  - outputs: pwr_up=0, rx_rdy=0, frm_err=0, rx_data=8'h00.
  - internal state: RX synchronizer flops preset to 1, receive FSM=IDLE, auth FSM=OFF.
- RX passes through a 2-flop synchronizer. All decisions use the synchronized value.
- Receive FSM:
  - IDLE: synchronized RX==0 -> START. Load the baud counter with BAUD_DIV/2 (1302).
  - START: counter decrements each clk. At 0:
    - RX==1 -> IDLE (glitch rejected, no pulses).
    - RX==0 -> DATA, reload BAUD_DIV, bit index=0.
  - DATA: at each counter expiry, shift the RX sample in LSB-first and reload BAUD_DIV. After the 8th bit -> STOP.
  - STOP: at counter expiry:
    - RX==1 -> rx_data updated, rx_rdy pulses the next clk.
    - RX==0 -> frm_err pulses the next clk, rx_data unchanged, no rx_rdy.
    - Either way -> IDLE.
- Latency: rx_rdy asserts 2 (sync) + 1302 + 9*2604 + 1 = 24741 clks after the RX falling edge at the pin.
- After STOP the receiver re-arms immediately. Back-to-back frames with a 1-bit stop and no idle gap must be received.
- Auth FSM, evaluated only in the cycle rx_rdy=1 (for commands) or on any cycle (for rider_off):
  - OFF:
    - rx_data==CMD_GO -> PWR1.
    - All other bytes are ignored.
  - PWR1:
    - CMD_STOP with rider_off=1 -> OFF.
    - CMD_STOP with rider_off=0 -> PWR2.
    - CMD_GO -> stay in PWR1.
    - Other bytes ignored.
  - PWR2:
    - rider_off=1 on any cycle -> OFF.
    - CMD_GO -> PWR1.
    - If CMD_GO arrives in the same cycle as rider_off=1, rider_off wins -> OFF.
- pwr_up is a registered output:
  - pwr_up=1 in PWR1 and PWR2, 0 in OFF.
  - It changes on the clk edge after the rx_rdy cycle (1-cycle latency).
- rider_off has no effect in PWR1. Power stays on until an 'S' is received.
- Framing-error bytes never reach the auth FSM.
- rst asserted mid-frame:
  - Everything returns to reset values immediately.
  - The remainder of the frame is not decoded. A mid-frame falling edge after release may be taken as a start bit; a garbled byte is acceptable there, but no hang.
- The baud counter is 12 bits wide. BAUD_DIV must fit in 12 bits; no wrap occurs within a frame.

Test Plan:
- Reset, then RX idle high for 50k clks -> pwr_up=0, no rx_rdy, no frm_err.
- Send 'G' (8'h47) at 19200 baud, rider_off=0:
  - rx_rdy pulses once, 24741±2 clks after the start edge, with rx_data=8'h47.
  - pwr_up=1 from the next clk.
- Power-down sequence, rider_off=0:
  - 'G' then 'S' -> pwr_up stays 1 (PWR2).
  - Then raise rider_off -> pwr_up=0 one clk later.
  - A 'G' sent before rider_off -> PWR1; a later rider_off alone leaves pwr_up=1.
- Invalid commands:
  - rider_off=1 then 'G','S' -> pwr_up 0->1->0.
  - Send 8'h41 in OFF and 8'h58 in PWR1 -> rx_rdy pulses, state and pwr_up unchanged.
- Framing error: frame 8'h47 with stop bit forced 0 -> frm_err pulses once, no rx_rdy, pwr_up stays 0, rx_data keeps its prior value.
- Glitch and reset robustness:
  - A 500-clk low pulse on RX -> rejected in START, no pulses.
  - Assert rst for 3 clks halfway through a 'G' frame -> pwr_up=0.
  - A following clean 'G' is received correctly.
